sfx_tone_sequencer: RTL and testbench

- Game sound-effect generator that feeds the audio output path of Audio_Controller.
- On request, it plays one of four short square-wave note sequences (hook launch, gold, rock, explosion) at the codec sample rate.
- One output sample is produced per accepted write on the controller's audio_out_allowed/write_audio_out handshake.
- Silence (0) is streamed when idle, so the output FIFO never starves.

---
 rtl/sfx_tone_sequencer.sv | 118 +++++++++++
 tb/tb_sfx_tone_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sfx_tone_sequencer.sv
// Square-wave sound-effect sequencer feeding the Audio_Controller output FIFO.
// Plays one of four short note sequences, one sample per accepted audio write.
module sfx_tone_sequencer #(
    parameter logic [31:0] AMPLITUDE    = 32'd10000000,
    parameter logic [15:0] NOTE_SAMPLES = 16'd4800
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        play_req,
    input  logic [1:0]  sfx_id,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state;
    logic [1:0]  effect;
    logic [1:0]  idx;
    logic [7:0]  phase_cnt;
    logic [15:0] sample_cnt;
    logic        pol;
    logic [31:0] sample;
    logic [7:0]  hp_cur;
    logic [7:0]  hp_next;
    logic        last_note;
    logic        tick;

    localparam logic [31:0] NEG_AMPLITUDE = '0 - AMPLITUDE;

    // Half-period table in samples; 0 terminates the effect.
    function automatic logic [7:0] half_period(input logic [1:0] fx, input logic [1:0] n);
        logic [7:0] hp;
        hp = '0;
        case ({fx, n})
            4'b00_00: hp = 8'd24;
            4'b01_00: hp = 8'd36;
            4'b01_01: hp = 8'd27;
            4'b01_10: hp = 8'd18;
            4'b10_00: hp = 8'd96;
            4'b10_01: hp = 8'd96;
            4'b11_00: hp = 8'd120;
            4'b11_01: hp = 8'd80;
            4'b11_10: hp = 8'd60;
            4'b11_11: hp = 8'd40;
            default:  hp = '0;
        endcase
        return hp;
    endfunction

    always_comb begin
        hp_cur    = half_period(effect, idx);
        hp_next   = half_period(effect, idx + 2'd1);
        last_note = (idx == 2'd3) || (hp_next == '0);
        tick      = audio_out_allowed;
    end

    assign write_audio_out         = audio_out_allowed;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            effect     <= '0;
            idx        <= '0;
            phase_cnt  <= '0;
            sample_cnt <= '0;
            pol        <= 1'b1;
            sample     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // A restart takes priority over any tick in the same cycle.
            if (play_req) begin
                state      <= PLAY;
                effect     <= sfx_id;
                idx        <= '0;
                phase_cnt  <= '0;
                sample_cnt <= '0;
                pol        <= 1'b1;
                sample     <= AMPLITUDE;
                busy       <= 1'b1;
            end else if (state == PLAY && tick) begin
                if (sample_cnt == NOTE_SAMPLES - 16'd1) begin
                    sample_cnt <= '0;
                    phase_cnt  <= '0;
                    pol        <= 1'b1;
                    if (last_note) begin
                        state  <= IDLE;
                        idx    <= '0;
                        sample <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx    <= idx + 2'd1;
                        sample <= AMPLITUDE;
                    end
                end else begin
                    sample_cnt <= sample_cnt + 16'd1;
                    if (phase_cnt == hp_cur - 8'd1) begin
                        phase_cnt <= '0;
                        pol       <= ~pol;
                        sample    <= pol ? NEG_AMPLITUDE : AMPLITUDE;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Scoreboard bench for sfx_tone_sequencer: expected sample stream is built from
// the note table on each request and consumed one entry per accepted write.
module tb_sfx_tone_sequencer;

    localparam int NS  = 48;
    localparam int AMP = 10000000;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        play_req = 1'b0;
    logic [1:0]  sfx_id = '0;
    logic        audio_out_allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        busy;
    logic        done;

    sfx_tone_sequencer #(
        .AMPLITUDE(32'd10000000),
        .NOTE_SAMPLES(16'd48)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .play_req(play_req),
        .sfx_id(sfx_id),
        .audio_out_allowed(audio_out_allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .busy(busy),
        .done(done)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad = 0;
    int hp_tab [4][4] = '{'{24, 0, 0, 0}, '{36, 27, 18, 0}, '{96, 96, 0, 0}, '{120, 80, 60, 40}};

    logic [31:0] q[$];
    logic        exp_done = 1'b0;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected stream: within a note, sample s has polarity from floor(s/hp) parity.
    task automatic build_seq(input logic [1:0] fx);
        int hp;
        for (int n = 0; n < 4; n++) begin
            hp = hp_tab[fx][n];
            if (hp == 0) break;
            for (int s = 0; s < NS; s++)
                q.push_back(((s / hp) % 2 == 0) ? AMP : -AMP);
        end
    endtask

    // Model update at each clock edge from the bench-driven inputs.
    always @(posedge CLOCK_50) begin
        if (reset) begin
            q.delete();
            exp_done = 1'b0;
            chk_en = 1'b1;
        end else if (play_req) begin
            q.delete();
            build_seq(sfx_id);
            exp_done = 1'b0;
        end else if (audio_out_allowed && q.size() != 0) begin
            void'(q.pop_front());
            exp_done = (q.size() == 0);
        end else begin
            exp_done = 1'b0;
        end
    end

    // Monitor: compare the presented sample and status away from the active edge.
    always @(negedge CLOCK_50) begin
        logic [31:0] exp_s;
        if (chk_en) begin
            exp_s = (q.size() != 0) ? q[0] : '0;
            check("left", left_channel_audio_out, exp_s);
            check("right", right_channel_audio_out, exp_s);
            check("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("write_mirror", {31'd0, write_audio_out}, {31'd0, audio_out_allowed});
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic play(input logic [1:0] fx);
        play_req = 1'b1;
        sfx_id = fx;
        step();
        play_req = 1'b0;
        sfx_id = $urandom_range(0, 3);
    endtask

    initial begin
        int nbusy;
        int seen;

        // Reset with allowed toggling
        for (int i = 0; i < 8; i++) begin
            audio_out_allowed = i[0];
            step();
        end
        reset = 1'b0;
        step();

        // sfx 0 with allowed held high; busy must last exactly 48 cycles
        audio_out_allowed = 1'b1;
        play(2'd0);
        nbusy = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge CLOCK_50);
            if (busy) nbusy++;
        end
        check("sfx0_busy_cycles", nbusy, 48);
        step();

        // sfx 3 with allowed high one cycle in four; bounded wait for done
        play(2'd3);
        seen = 0;
        for (int c = 0; c < 1500 && seen == 0; c++) begin
            audio_out_allowed = (c % 4 == 0);
            step();
            if (done) seen = 1;
        end
        check("sfx3_done_seen", seen, 1);
        audio_out_allowed = 1'b1;
        repeat (3) step();

        // sfx 2 restarted by sfx 1 at tick 60
        play(2'd2);
        repeat (59) step();
        play(2'd1);
        repeat (110) step();

        // reset mid-effect at tick 30 of sfx 1, then clean start
        play(2'd1);
        repeat (29) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        play(2'd1);
        repeat (100) step();

        // restart coincident with the final tick of sfx 0
        play(2'd0);
        repeat (47) step();
        play(2'd0);
        repeat (55) step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            audio_out_allowed = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            play_req = ($urandom_range(0, 79) == 0);
            sfx_id = $urandom_range(0, 3);
            step();
        end
        reset = 1'b0;
        play_req = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
